router_fifo: RTL and testbench

Per-port output buffer of the 1x3 router. One instance per destination port, directly downstream of the router synchroniser, which supplies `write_enb[n]`, `soft_reset_n` and `read_enb_n`. This block reports `full` and `empty` back to the synchroniser, where they become `fifo_full` and `vld_out_n`. It stores 16 entries of 8-bit packet bytes, each tagged with a header flag. It also tracks the packet length on the read side, so the output bus is cleared once a packet has been fully drained.

---
 rtl/router_fifo.sv | 78 +++++++
 tb/tb_router_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
// Per-port output buffer of the 1x3 router: a DEPTH x {lfd, byte} FIFO.
// It also tracks the remaining packet length on the read side so data_out can return to zero once a packet is drained.
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE_C = {{AW{1'b0}}, 1'b1};

    logic [WIDTH:0]   mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [6:0]       count_r;
    logic [WIDTH-1:0] data_out_r;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic             clr_s;
    logic [WIDTH:0]   rd_entry_s;

    // The pointer MSB is the wrap bit: equal pointers mean empty, and a differing MSB with equal low bits means full.
    assign empty    = (wr_ptr_r == rd_ptr_r);
    assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign data_out = data_out_r;

    // Accept decisions use the pre-edge flags only.
    always_comb begin
        clr_s      = reset || soft_reset;
        wr_acc_s   = write_enb && !full;
        rd_acc_s   = read_enb && !empty;
        rd_entry_s = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Storage write port; memory contents survive resets.
    always_ff @(posedge clock) begin
        if (!clr_s && wr_acc_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    // Pointers, packet counter and registered read data.
    always_ff @(posedge clock) begin
        if (clr_s) begin
            wr_ptr_r   <= {(AW+1){1'b0}};
            rd_ptr_r   <= {(AW+1){1'b0}};
            count_r    <= 7'd0;
            data_out_r <= {WIDTH{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (rd_acc_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_ONE_C;
                data_out_r <= rd_entry_s[WIDTH-1:0];
                // A header reloads the counter with payload length plus the parity byte.
                if (rd_entry_s[WIDTH]) begin
                    count_r <= {1'b0, rd_entry_s[7:2]} + 7'd1;
                end else if (count_r != 7'd0) begin
                    count_r <= count_r - 7'd1;
                end
            end else if (count_r == 7'd0) begin
                data_out_r <= {WIDTH{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: a vector table for packet-length behaviour plus
// hand-written sequences for fill/drain, simultaneous access, wrap, soft reset and reset priority.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       read_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int errors = 0;
    int checks = 0;

    router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       sr;
        logic       we;
        logic       re;
        logic       lfd;
        logic [7:0] din;
        logic [7:0] exp_d;
        logic       exp_f;
        logic       exp_e;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [7:0] ed, input logic ef, input logic ee);
        checks++;
        if (data_out !== ed || full !== ef || empty !== ee) begin
            errors++;
            $display("FAIL %s: got data_out=%h full=%b empty=%b, expected data_out=%h full=%b empty=%b",
                     name, data_out, full, empty, ed, ef, ee);
        end
    endtask

    // Apply one set of inputs across one rising edge; outputs are sampled 1 time unit later.
    task automatic cyc(input logic sr, input logic we, input logic re, input logic lfd, input logic [7:0] d);
        soft_reset = sr;
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = d;
        @(posedge clock);
        #1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        reset = 1'b0;
    endtask

    initial begin
        // sr, we, re, lfd, din, exp data_out, exp full, exp empty
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h0C, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hA1, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hA2, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hA3, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h5E, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h0C, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA2, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA3, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h5E, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 8'h00, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h77, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h08, 8'h00, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hB1, 8'h00, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hB1, 1'b0, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hB1, 1'b0, 1'b1};

        // Reset state
        do_reset();
        chk("reset_state", 8'h00, 1'b0, 1'b1);

        // Packet length, stray byte and hold behaviour
        for (int i = 0; i < 21; i++) begin
            cyc(vecs[i].sr, vecs[i].we, vecs[i].re, vecs[i].lfd, vecs[i].din);
            chk($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_f, vecs[i].exp_e);
        end

        // Fill/drain
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'(i + 1));
            chk($sformatf("fill%0d", i), 8'h00, (i == 15) ? 1'b1 : 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        chk("write_when_full", 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            chk($sformatf("drain%0d", i), 8'(i + 1), 1'b0, (i == 15) ? 1'b1 : 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("read_after_drain", 8'h00, 1'b0, 1'b1);

        // Simultaneous read/write at 8 entries
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'(8'h28 + i));
            chk($sformatf("rw_mid%0d", i), 8'(8'h20 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            chk($sformatf("rw_mid_drain%0d", i), 8'(8'h2A + i), 1'b0, (i == 7) ? 1'b1 : 1'b0);
        end

        // Simultaneous read/write at full, then at empty
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
        chk("full_before_rw", 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
        chk("rw_full", 8'h80, 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            chk($sformatf("rw_full_drain%0d", i), 8'(8'h80 + i), 1'b0, (i == 15) ? 1'b1 : 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
        chk("rw_empty", 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("rw_empty_readback", 8'h55, 1'b0, 1'b1);

        // Wrap-around: 40 writes, reads start once 15 entries are buffered
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b1, (i >= 15) ? 1'b1 : 1'b0, 1'b0, 8'(8'h40 + i));
            chk($sformatf("wrap%0d", i), (i >= 15) ? 8'(8'h40 + i - 15) : 8'h00, 1'b0, 1'b0);
        end
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            chk($sformatf("wrap_drain%0d", i), 8'(8'h40 + 25 + i), 1'b0, (i == 14) ? 1'b1 : 1'b0);
        end

        // Soft reset mid-packet with a concurrent write
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'hC1 + i));
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("sr_pre_hdr", 8'h10, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("sr_pre_byte", 8'hC1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
        chk("soft_reset", 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h04);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'hD1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'hD2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("sr_post_hdr", 8'h04, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("sr_post_byte", 8'hD1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("sr_post_parity", 8'hD2, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("sr_post_idle", 8'h00, 1'b0, 1'b1);

        // Reset priority over soft reset, write and read
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h0C);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'hE1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'hE2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("rp_pre", 8'h0C, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h66);
        reset = 1'b0;
        chk("reset_priority", 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("reset_priority_after", 8'h00, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
